// File: rtl/systolic_feeder.sv
// Edge feeder for an output-stationary systolic MAC array: buffers one N x N tile, then streams it
// with diagonal skew. Optional macro FEEDER_TRANSPOSE_EN streams the buffered vectors transposed.
module systolic_feeder #(
  parameter int data_size = 8,
  parameter int N         = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [N*data_size-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   start,
  output logic                   busy,
  output logic [N*data_size-1:0] feed_out,
  output logic                   mac_clear,
  output logic                   done
);

  localparam int PW = $clog2(N + 1);
  localparam int CW = $clog2(2 * N - 1);
  localparam logic [PW-1:0] FULL   = PW'(N);
  localparam logic [CW-1:0] LAST_T = CW'(2 * N - 2);
  localparam logic [CW-1:0] LAST_D = CW'(N);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [PW-1:0]          wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]          step, step_nxt;
  logic [N*data_size-1:0] tile_mem [N];
  logic [N*data_size-1:0] skew_vec;
  logic                   start_ok, write_ok, drain_end;

  // A start only counts against a completely filled buffer, sampled before any same-cycle write.
  assign start_ok  = (state == IDLE) && start && (wr_ptr == FULL);
  assign write_ok  = (state == IDLE) && wr_en && (wr_ptr < FULL);
  assign drain_end = (state == DRAIN) && (step == LAST_D);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok)       state_nxt = STREAM;
      STREAM:  if (step == LAST_T) state_nxt = DRAIN;
      DRAIN:   if (drain_end)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // NOTE: every comb output gets a default up front so no path can leave it unassigned (no latch).
  always_comb begin
    step_nxt   = '0;
    wr_ptr_nxt = wr_ptr;
    unique case (state)
      IDLE:   if (write_ok) wr_ptr_nxt = wr_ptr + PW'(1);
      STREAM: step_nxt = (step == LAST_T) ? '0 : step + CW'(1);
      DRAIN: begin
        if (drain_end) wr_ptr_nxt = '0;
        else           step_nxt   = step + CW'(1);
      end
      default: ;
    endcase
  end

  // Step t places vector r's lane i on lane i when r + i == t; everything else is zero padding.
  always_comb begin
    skew_vec = '0;
    if (state == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int r = 0; r < N; r++) begin
          if (r + i == int'(step)) begin
`ifdef FEEDER_TRANSPOSE_EN
            skew_vec[i*data_size +: data_size] = tile_mem[i][r*data_size +: data_size];
`else
            skew_vec[i*data_size +: data_size] = tile_mem[r][i*data_size +: data_size];
`endif
          end
        end
      end
    end
  end

  // NOTE: the tile buffer is cleared on reset so an aborted tile never leaks into a later stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) tile_mem[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (write_ok && (wr_ptr == PW'(k))) tile_mem[k] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      step      <= '0;
      feed_out  <= '0;
      mac_clear <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      wr_ready  <= 1'b1;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      step      <= step_nxt;
      feed_out  <= skew_vec;
      mac_clear <= start_ok;
      done      <= drain_end;
      busy      <= (state_nxt != IDLE);
      wr_ready  <= (state_nxt == IDLE) && (wr_ptr_nxt < FULL);
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a tile-level model queues the expected per-cycle response
// of every accepted start; a negedge monitor pops and compares whenever a response is due.
module tb_systolic_feeder;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int VW = N * DW;

  typedef struct {
    logic [VW-1:0] feed;
    logic          mac_clear;
    logic          done;
    logic          busy;
    logic          wr_ready;
  } rec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] wr_data = '0;
  logic          wr_ready, busy, mac_clear, done;
  logic [VW-1:0] feed_out;

  rec_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] tile [N][N];  // tile[vector][lane]
  int            model_ptr = 0;

  systolic_feeder #(.data_size(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .busy(busy), .feed_out(feed_out), .mac_clear(mac_clear), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element streamed on lane i at step t, straight from the skew rule.
  function automatic logic [DW-1:0] lane_at(input int t, input int i);
    int r;
    r = t - i;
    if (r < 0 || r >= N) return '0;
`ifdef FEEDER_TRANSPOSE_EN
    return tile[i][r];
`else
    return tile[r][i];
`endif
  endfunction

  // Cycle c after start acceptance: c=0 clear pulse, c=1..2N-1 skewed data, then drain, c=3N done.
  task automatic push_expected();
    rec_t rec;
    for (int c = 0; c <= 3 * N; c++) begin
      rec.feed = '0;
      if (c >= 1 && c <= 2 * N - 1)
        for (int i = 0; i < N; i++) rec.feed[i*DW +: DW] = lane_at(c - 1, i);
      rec.mac_clear = (c == 0);
      rec.done      = (c == 3 * N);
      rec.busy      = (c != 3 * N);
      rec.wr_ready  = (c == 3 * N);
      exp_q.push_back(rec);
    end
  endtask

  task automatic model_write(input logic [VW-1:0] v);
    if (model_ptr < N) begin
      for (int i = 0; i < N; i++) tile[model_ptr][i] = v[i*DW +: DW];
      model_ptr++;
    end
  endtask

  task automatic write_vec(input logic [VW-1:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
    model_write(v);
  endtask

  // Pulse start; if accepted, run the full 3N-cycle window, optionally jamming wr_en/start,
  // spot-checking step t=2, or aborting with reset after abort_at cycles.
  task automatic try_start(input bit jam, input int abort_at, input bit spot,
                           input logic [VW-1:0] spot_val);
    bit accepted;
    accepted = (model_ptr == N);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!accepted) return;
    push_expected();
    for (int k = 1; k <= 3 * N; k++) begin
      if (k == abort_at) begin
        wr_en = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        repeat (3) tick();
        reset = 1'b1;
        return;
      end
      if (jam) begin
        wr_en   = 1'($urandom);
        start   = 1'($urandom);
        wr_data = VW'($urandom);
      end
      tick();
      if (spot && k == 3) check("spot_t2", feed_out, spot_val);
    end
    wr_en = 1'b0;
    start = 1'b0;
    model_ptr = 0;
  endtask

  always @(negedge clk) begin : monitor
    rec_t e;
    if (!reset) begin
      check("rst_feed", feed_out, '0);
      check("rst_activity", {done, mac_clear, busy}, 3'b000);
      check("rst_wr_ready", wr_ready, 1'b1);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("feed_out", feed_out, e.feed);
      check("mac_clear", mac_clear, e.mac_clear);
      check("done", done, e.done);
      check("busy", busy, e.busy);
      check("wr_ready", wr_ready, e.wr_ready);
    end else begin
      check("idle_activity", {done, mac_clear, busy}, 3'b000);
      check("idle_feed", feed_out, '0);
      check("idle_wr_ready", wr_ready, model_ptr < N);
    end
  end

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] spot_val;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Directed tile: vector k, lane i = 10k + i + 1.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(10 * k + i + 1);
      write_vec(v);
    end
`ifdef FEEDER_TRANSPOSE_EN
    spot_val = {8'd0, 8'd21, 8'd12, 8'd3};
`else
    spot_val = {8'd0, 8'd3, 8'd12, 8'd21};
`endif
    try_start(1'b0, 0, 1'b1, spot_val);

    // Premature start after three writes, then write and start in the same cycle.
    repeat (3) write_vec(VW'($urandom));
    try_start(1'b0, 0, 1'b0, '0);
    v = VW'($urandom);
    wr_en = 1'b1;
    start = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    model_write(v);
    try_start(1'b1, 0, 1'b0, '0);

    // Overflow write while full must not disturb the tile.
    repeat (4) write_vec(VW'($urandom));
    write_vec(VW'($urandom));
    try_start(1'b1, 0, 1'b0, '0);

    // Reset mid-stream, then start is ignored until the buffer is refilled.
    repeat (4) write_vec(VW'($urandom));
    try_start(1'b0, 6, 1'b0, '0);
    try_start(1'b0, 0, 1'b0, '0);
    repeat (4) write_vec(VW'($urandom));
    try_start(1'b0, 0, 1'b0, '0);

    // Randomised tiles, gaps, surplus writes and jamming.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(4, 6)) begin
        write_vec(VW'($urandom));
        repeat ($urandom_range(0, 2)) tick();
      end
      try_start(1'($urandom), 0, 1'b0, '0);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (2) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Edge feeder for the output-stationary systolic MAC array.
- Buffers one N x N operand tile (N vectors of N lanes), then streams it into the array edge with diagonal skew: lane i is delayed by i cycles, and unused slots are zero-padded.
- Issues the accumulator-clear pulse to the array before the first operand arrives, and signals completion once the last product has settled.
- One instance feeds the A edge and one feeds the B edge.

Parameters:
- data_size, 8, operand width per lane (matches the MAC operand width).
- N, 4, array dimension: lane count and tile depth; N >= 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for one tile vector.
- wr_data  input  N*data_size  tile vector; lane i = bits [i*data_size +: data_size].
- wr_ready  output  1  vector slot available.
- start  input  1  request to stream the buffered tile.
- busy  output  1  streaming or draining in progress.
- feed_out  output  N*data_size  skewed edge data; lane i drives array row/column i.
- mac_clear  output  1  one-cycle clear pulse to the MAC array (active-high synchronous reset of the PEs).
- done  output  1  one-cycle pulse: tile fully streamed and all products settled.

Behaviour:
- Reset (asynchronous, reset=0):
  - State to IDLE; write pointer wr_ptr=0; all buffer entries 0.
  - feed_out=0, mac_clear=0, done=0, busy=0, wr_ready=1.
  - Reset mid-stream aborts immediately; the buffer contents are lost.
- All outputs are registered.
- States: IDLE (loading), STREAM, DRAIN.
- IDLE:
  - wr_ready = (wr_ptr < N).
  - wr_en & wr_ready: buf[wr_ptr] <= wr_data, wr_ptr++.
  - wr_en while wr_ready=0 is ignored; no overwrite.
  - start is accepted only when wr_ptr==N; otherwise ignored, with no side effects.
- Start accepted at edge E0:
  - State to STREAM; busy=1; wr_ready=0; mac_clear=1 for the single cycle after E0; feed_out=0 in that cycle; step counter t=0.
- STREAM, at edges E1..E(2N-1), for t = 0..2N-2:
  - Lane i of feed_out = buf[t-i][i] when 0 <= t-i <= N-1, else 0.
  - t increments each edge; after t=2N-2 the state moves to DRAIN.
- DRAIN, edges E(2N)..E(3N-1):
  - feed_out=0 for N cycles so the final PE captures its last product.
- At edge E(3N): state to IDLE; done=1 for one cycle; busy=0; wr_ptr=0; wr_ready=1.
- Writes are legal again from the cycle in which done is high.
- wr_en and start during STREAM or DRAIN are ignored.
- Total latency: 3N edges from start acceptance to done.
- start and wr_en in the same IDLE cycle when wr_ptr==N-1: the write is taken, and start is ignored because the buffer was not full at sampling.
- Widths: values pass through unchanged; no arithmetic on data.
- Counters: t wraps only via the state transition and never exceeds 2N-2; wr_ptr saturates at N.

Optional Feature:
- Macro: FEEDER_TRANSPOSE_EN.
- Defined: lane i of feed_out at step t = buf[i][t-i] for 0 <= t-i <= N-1, else 0. Written vectors are treated as rows that get transposed, so the A-side feeder accepts row-major A.
- Undefined: normal indexing buf[t-i][i] as in Behaviour; the transpose mux is not synthesised.

Test Plan:
- Reset check: hold reset=0 mid-STREAM -> feed_out=0, mac_clear=0, done=0, busy=0, wr_ready=1 while reset is low; after release, start is ignored until 4 new writes.
- Fill and skew (N=4, data_size=8): write vector k with lane i = 10k+i+1, then start at E0:
  - Cycle after E0: mac_clear=1, feed_out=0.
  - After E1 (t=0): lanes {0,1,2,3} = {1,0,0,0}.
  - After E3 (t=2): {21,12,3,0}.
  - After E7 (t=6): {0,0,0,34}.
- Completion timing: same run -> feed_out=0 after E8..E11; done=1 only in the cycle after E12; busy falls with done.
- Premature start: 3 writes, then start -> state stays IDLE, no mac_clear pulse, wr_ready=1; 4th write then start -> stream proceeds normally.
- Overflow and ignored writes: 5th wr_en while full -> wr_ready=0, buffer unchanged. wr_en and start pulsed during STREAM -> no effect on the streamed values or on the done timing.
- FEEDER_TRANSPOSE_EN defined, same tile -> t=2 lanes = {21,? } replaced by buf[i][2-i]: {3,12,21,0}.
